// File: rtl/fetch_control.sv
// ---------------------------------------------------------------------------
// fetch_control
//
// Instruction-fetch sequencer. It issues one memory read per instruction,
// holds the returned word for the decoder, and decodes the jump class of
// the held word for the next-PC logic.
//
// Lifecycle of one fetch:
//   IDLE  -> sample pc_in, raise mem_req
//   FETCH -> wait for mem_ack, give up after TIMEOUT cycles
//   HOLD  -> present instr_out until the decoder accepts it, then strobe pc_en
//   ERROR -> sticky; only reset leaves it
//
// Ports
//   clock        in   1   rising-edge clock
//   reset        in   1   asynchronous, active-low reset
//   pc_in        in   32  current fetch address from the program counter
//   mem_req      out  1   read request, held until ack or timeout
//   mem_addr     out  32  read address, stable for the whole request
//   mem_ack      in   1   read data valid (only honoured in FETCH)
//   mem_rdata    in   32  instruction word
//   instr_out    out  32  held instruction
//   instr_valid  out  1   instr_out holds an unconsumed instruction
//   instr_ready  in   1   decoder accepts instr_out
//   pc_func      out  2   next-PC select: 00 seq, 01 JAL, 10 JALR
//   pc_offset    out  22  sign-extended jump immediate
//   pc_rs1       out  5   JALR base register index
//   pc_en        out  1   one-cycle PC advance strobe (handshake cycle)
//   fetch_err    out  1   sticky error: misaligned address or timeout
// ---------------------------------------------------------------------------
module fetch_control #(
  parameter int TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [1:0]  pc_func,
  output logic [21:0] pc_offset,
  output logic [4:0]  pc_rs1,
  output logic        pc_en,
  output logic        fetch_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    ERROR
  } state_e;

  state_e        state_q,    state_d;
  logic          mem_req_q,  mem_req_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   instr_q,    instr_d;
  logic          valid_q,    valid_d;
  logic          err_q,      err_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  // NOTE: every register shares one asynchronous reset so that a reset in
  // the middle of a request drops mem_req immediately, not on the next edge.
  // Non-blocking assignments keep all registers updating from the same
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  // NOTE: every next-state signal defaults to its current value before the
  // case, so no path through the block leaves a signal unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    err_d      = err_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (pc_in[1:0] != 2'b00) begin
          err_d   = 1'b1;
          state_d = ERROR;
        end else begin
          mem_addr_d = pc_in;
          mem_req_d  = 1'b1;
          cnt_d      = '0;
          state_d    = FETCH;
        end
      end

      FETCH: begin
        // Ack is tested first so that an ack on the final wait cycle wins
        // over the timeout.
        if (mem_ack) begin
          instr_d   = mem_rdata;
          valid_d   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = HOLD;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ERROR;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      HOLD: begin
        if (instr_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end

      ERROR: begin
        mem_req_d = 1'b0;
        valid_d   = 1'b0;
        err_d     = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  // Jump decode is a pure function of the held word, so it is stable for as
  // long as instr_out is; it is gated to HOLD so the PC-control outputs read
  // zero whenever no instruction is being presented.
  always_comb begin
    pc_func   = 2'b00;
    pc_offset = '0;
    pc_rs1    = '0;
    if (state_q == HOLD) begin
      unique case (instr_q[6:0])
        OP_JAL: begin
          pc_func   = 2'b01;
          pc_offset = {instr_q[31], instr_q[31], instr_q[19:12], instr_q[20],
                       instr_q[30:21], 1'b0};
        end
        OP_JALR: begin
          pc_func   = 2'b10;
          pc_rs1    = instr_q[19:15];
          pc_offset = {{10{instr_q[31]}}, instr_q[31:20]};
        end
        default: ;
      endcase
    end
  end

  assign pc_en       = (state_q == HOLD) && instr_ready;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_control.sv
// ---------------------------------------------------------------------------
// tb_fetch_control
//
// Self-checking bench for fetch_control. The stimulus process plays the
// memory and the decoder, and queues the expected outcome of each fetch.
// A separate monitor pops that queue whenever the DUT completes a handshake
// (pc_en) or raises fetch_err, and compares the presented values. Inputs are
// driven on the falling edge; outputs are sampled away from the rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_control;

  typedef enum logic {EV_HS, EV_ERR} ev_e;

  typedef struct {
    ev_e         kind;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [1:0]  func;
    logic [21:0] off;
    logic [4:0]  rs1;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [31:0] pc_in;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  pc_func;
  logic [21:0] pc_offset;
  logic [4:0]  pc_rs1;
  logic        pc_en;
  logic        fetch_err;

  int   vectors    = 0;
  int   miscompares = 0;
  exp_t sb[$];
  logic err_prev = 1'b0;

  fetch_control #(.TIMEOUT(15)) dut (
    .clock       (clock),
    .reset       (reset),
    .pc_in       (pc_in),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_func     (pc_func),
    .pc_offset   (pc_offset),
    .pc_rs1      (pc_rs1),
    .pc_en       (pc_en),
    .fetch_err   (fetch_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".mem_req"},     mem_req,     0);
    check({tag, ".mem_addr"},    mem_addr,    0);
    check({tag, ".instr_out"},   instr_out,   0);
    check({tag, ".instr_valid"}, instr_valid, 0);
    check({tag, ".pc_func"},     pc_func,     0);
    check({tag, ".pc_offset"},   pc_offset,   0);
    check({tag, ".pc_rs1"},      pc_rs1,      0);
    check({tag, ".pc_en"},       pc_en,       0);
    check({tag, ".fetch_err"},   fetch_err,   0);
  endtask

  // Monitor: compares each handshake / error event against the queue head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        if (pc_en) begin
          if (sb.size() == 0) begin
            check("sb_unexpected_pc_en", 1, 0);
          end else begin
            e = sb.pop_front();
            check("hs_kind",      pc_en && (e.kind == EV_HS), 1);
            check("hs_mem_addr",  mem_addr,  e.addr);
            check("hs_instr_out", instr_out, e.instr);
            check("hs_valid",     instr_valid, 1);
            check("hs_pc_func",   pc_func,   e.func);
            check("hs_pc_offset", pc_offset, e.off);
            check("hs_pc_rs1",    pc_rs1,    e.rs1);
          end
        end
        if (fetch_err && !err_prev) begin
          if (sb.size() == 0) begin
            check("sb_unexpected_err", 1, 0);
          end else begin
            e = sb.pop_front();
            check("err_kind", e.kind == EV_ERR, 1);
          end
        end
      end
      err_prev = fetch_err;
    end
  end

  // One complete fetch: d cycles without ack after the request appears,
  // then ack; r cycles of decoder back-pressure, then ready.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] rdata,
                          input int d, input int r, input logic [1:0] f,
                          input logic [21:0] off, input logic [4:0] rs1);
    exp_t e;
    int   n;
    e = '{kind: EV_HS, addr: addr, instr: rdata, func: f, off: off, rs1: rs1};
    sb.push_back(e);
    pc_in = addr;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!mem_req && n < 4);
    check("req_rise",   mem_req,  1);
    check("req_addr",   mem_addr, addr);
    repeat (d) @(negedge clock);
    check("req_held",   mem_req,  1);
    check("addr_held",  mem_addr, addr);
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    @(negedge clock);
    mem_ack   = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    check("cap_valid",  instr_valid, 1);
    check("cap_req",    mem_req,     0);
    check("cap_instr",  instr_out,   rdata);
    for (int i = 0; i < r; i++) begin
      check("wait_pc_en", pc_en, 0);
      @(negedge clock);
      check("wait_instr", instr_out, rdata);
      check("wait_func",  pc_func,   f);
    end
    instr_ready = 1'b1;
    #1;
    check("hs_pc_en",   pc_en, 1);
    @(negedge clock);
    instr_ready = 1'b0;
    #1;
    check("post_valid", instr_valid, 0);
    check("post_pc_en", pc_en,       0);
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic do_reset(input string tag, input logic [31:0] next_pc);
    @(negedge clock);
    #3;
    reset = 1'b0;
    #1;
    check_all_zero(tag);
    pc_in = next_pc;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin : stimulus
    exp_t e;
    reset       = 1'b0;
    pc_in       = 32'h0;
    mem_ack     = 1'b0;
    mem_rdata   = 32'h0;
    instr_ready = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Sequential, JAL with back-pressure, JALR, negative JAL.
    do_fetch(32'h0000_0000, 32'h0000_0013, 2, 0, 2'b00, 22'h000000, 5'd0);
    do_fetch(32'h0000_0004, 32'h0080_006F, 0, 5, 2'b01, 22'h000008, 5'd0);
    do_fetch(32'h0000_0008, 32'hFFC0_8067, 1, 0, 2'b10, 22'h3FFFFC, 5'd1);
    do_fetch(32'h0000_000C, 32'hFFDF_F06F, 0, 0, 2'b01, 22'h3FFFFC, 5'd0);
    // Ack on the 15th wait cycle beats the timeout.
    do_fetch(32'h0000_0010, 32'h00C0_00EF, 14, 0, 2'b01, 22'h00000C, 5'd0);
    check("ack15_no_err", fetch_err, 0);

    // Timeout: no ack for 15 cycles.
    e = '{kind: EV_ERR, addr: 32'h0, instr: 32'h0, func: 2'b00, off: '0, rs1: '0};
    sb.push_back(e);
    pc_in = 32'h0000_0014;
    @(negedge clock);
    check("to_req_rise", mem_req, 1);
    repeat (14) @(negedge clock);
    check("to_req_last", mem_req,   1);
    check("to_err_last", fetch_err, 0);
    @(negedge clock);
    check("to_req_drop", mem_req,   0);
    check("to_err_set",  fetch_err, 1);
    // Sticky, and late acks are ignored.
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_006F;
    instr_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("err_sticky", fetch_err,   1);
    check("err_no_req", mem_req,     0);
    check("err_no_val", instr_valid, 0);
    check("err_no_en",  pc_en,       0);
    mem_ack     = 1'b0;
    instr_ready = 1'b0;
    do_reset("rst_err", 32'h0000_0002);

    // Misaligned address goes straight to error without a request.
    e = '{kind: EV_ERR, addr: 32'h0, instr: 32'h0, func: 2'b00, off: '0, rs1: '0};
    sb.push_back(e);
    @(negedge clock);
    check("mis_no_req", mem_req,   0);
    check("mis_err",    fetch_err, 1);
    do_reset("rst_mis", 32'h0000_0020);

    // First request issues on the first edge after reset release.
    @(negedge clock);
    check("first_req",  mem_req,  1);
    check("first_addr", mem_addr, 32'h0000_0020);
    // Abandon it with a reset mid-FETCH.
    do_reset("rst_fetch", 32'h0000_0024);

    // Clean recovery after the abandoned request.
    do_fetch(32'h0000_0024, 32'h0000_0013, 0, 1, 2'b00, 22'h000000, 5'd0);

    repeat (2) @(negedge clock);
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_control.md
FETCH_CONTROL -- requirements
Module: fetch_control

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum number of wait cycles for mem_ack before an error is raised.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port pc_in, input, 32 bits: the current fetch address from the program counter.
REQ-005 The block SHALL have the memory-side ports: mem_req (output, 1, read request), mem_addr (output, 32, read address), mem_ack (input, 1, data valid), and mem_rdata (input, 32, instruction word).
REQ-006 The block SHALL have the decoder-side ports: instr_out (output, 32, held instruction), instr_valid (output, 1), and instr_ready (input, 1).
REQ-007 The block SHALL have the PC-control ports: pc_func (output, 2, next-PC select), pc_offset (output, 22, immediate), pc_rs1 (output, 5, register index), and pc_en (output, 1, one-cycle PC advance strobe).
REQ-008 The block SHALL have port fetch_err, output, 1 bit: a sticky error flag.

Function
REQ-009 The block SHALL implement four states: IDLE, FETCH, HOLD and ERROR.
REQ-010 IDLE: if pc_in[1:0] != 0, the block SHALL go to ERROR; otherwise it SHALL register mem_addr <= pc_in, assert mem_req, clear the wait counter and go to FETCH.
REQ-011 FETCH: the block SHALL hold mem_req=1 and mem_addr stable until mem_ack is sampled high, and the wait counter SHALL increment every cycle without ack.
REQ-012 FETCH with mem_ack=1: the block SHALL capture instr_out <= mem_rdata, set instr_valid=1, drop mem_req, and go to HOLD, so instr_valid rises on the edge that sampled ack.
REQ-013 FETCH with the counter reaching TIMEOUT and no ack: the block SHALL drop mem_req, set fetch_err=1 and go to ERROR; when ack and timeout occur in the same cycle, ack SHALL win.
REQ-014 mem_ack sampled outside FETCH SHALL be ignored.
REQ-015 HOLD: instr_out, instr_valid, pc_func, pc_offset and pc_rs1 SHALL remain stable until instr_ready=1.
REQ-016 HOLD decode, opcode = instr_out[6:0], 1101111 (JAL): pc_func SHALL be 01 and pc_offset SHALL be the sign-extension to 22 bits of {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
REQ-017 HOLD decode, opcode 1100111 (JALR): pc_func SHALL be 10, pc_rs1 SHALL be instr[19:15], and pc_offset SHALL be instr[31:20] sign-extended to 22 bits.
REQ-018 HOLD decode, all other opcodes: pc_func SHALL be 00, with pc_offset=0 and pc_rs1=0; pc_func=11 SHALL never be driven.
REQ-019 HOLD with instr_ready=1: pc_en SHALL pulse high for exactly that one cycle together with valid pc_func, pc_offset and pc_rs1; instr_valid SHALL clear on the next edge, and the state SHALL return to IDLE.
REQ-020 The block SHALL spend one IDLE cycle after each handshake so that the updated pc_in is sampled, giving a minimum fetch period of 3 cycles plus memory latency.
REQ-021 In ERROR, mem_req, pc_en and instr_valid SHALL stay 0 and fetch_err SHALL stay 1 until reset.
REQ-022 pc_en SHALL never be asserted outside HOLD.

Reset
REQ-023 While reset=0, the block SHALL asynchronously force: state=IDLE; mem_req=0; mem_addr=0; instr_out=0; instr_valid=0; pc_func=00; pc_offset=0; pc_rs1=0; pc_en=0; fetch_err=0; wait counter=0.
REQ-024 Reset asserted mid-FETCH or mid-HOLD SHALL abandon the transaction immediately, with mem_req low in the same cycle and the handshake not completed.
REQ-025 After reset deasserts, the first request SHALL issue from IDLE on the first rising edge.

Verification
REQ-026 Sequential fetch: pc_in=0x00000000, ack after 2 cycles, rdata=0x00000013, instr_ready=1 -> mem_addr=0x0, instr_valid for 1 cycle, pc_func=00, and pc_en pulses once.
REQ-027 JAL decode: rdata=0x0080006F -> pc_func=01, pc_offset=0x000008, pc_en held low until instr_ready is raised 5 cycles later.
REQ-028 JALR decode: rdata=0xFFC08067 -> pc_func=10, pc_rs1=1, pc_offset=0x3FFFFC.
REQ-029 Timeout: no ack for 15 cycles -> mem_req drops, fetch_err=1 sticky; ack arriving on cycle 15 instead -> normal capture, fetch_err=0.
REQ-030 Misaligned address: pc_in=0x00000002 -> no mem_req, fetch_err=1; then reset low mid-FETCH of the next test -> all outputs 0 asynchronously.
